// File: rtl/reduce_stream_acc.sv
// reduce_stream_acc
// Folds a framed valid/ready stream of W-bit words into one W-bit result using
// a per-frame operator (AND, OR, XOR, NAND) and also reports a 1-bit reduction
// of the folded value. One result is delivered per frame over a valid/ready
// output handshake. A frame ends on in_last or when MAX_BEATS beats have been
// accepted, whichever comes first. In the MAX_BEATS case out_err flags the
// forced termination, and the producer's remaining beats start a new frame.
//
// Optional build macro: REDUCE_BEATCNT_EN adds out_beats, the beat count of
// the delivered frame.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   op         operator 00 AND, 01 OR, 10 XOR, 11 NAND (taken on first beat)
//   in_data    input word
//   in_valid   producer has a word
//   in_last    final beat of the producer frame
//   in_ready   block accepts a beat this cycle (state-only, no out_ready path)
//   out_data   frame result
//   out_red    1-bit reduction of the accumulator under the frame operator
//   out_err    frame was cut at MAX_BEATS rather than by in_last
//   out_valid  result available
//   out_ready  consumer accepts the result
//   out_beats  (REDUCE_BEATCNT_EN only) number of beats in the frame
module reduce_stream_acc #(
    parameter int W         = 8,
    parameter int MAX_BEATS = 16,
    localparam int CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    op,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [W-1:0]  out_data,
    output logic          out_red,
    output logic          out_err,
    output logic          out_valid,
`ifdef REDUCE_BEATCNT_EN
    output logic [CW-1:0] out_beats,
`endif
    input  logic          out_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [1:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          beat_s;
    logic [CW-1:0] cnt_inc_s;

    // NAND folds as AND; the inversion is applied only at the output.
    function automatic logic [W-1:0] fold_word(input logic [1:0] f_op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        case (f_op)
            2'b01:   fold_word = a | b;
            2'b10:   fold_word = a ^ b;
            default: fold_word = a & b;
        endcase
    endfunction

    function automatic logic reduce_word(input logic [1:0] f_op,
                                         input logic [W-1:0] a);
        case (f_op)
            2'b00:   reduce_word = &a;
            2'b01:   reduce_word = |a;
            2'b10:   reduce_word = ^a;
            default: reduce_word = ~&a;
        endcase
    endfunction

    // in_ready comes from state alone so no out_ready -> in_ready path exists.
    assign in_ready  = (state_q != S_DONE);
    assign out_valid = (state_q == S_DONE);
    assign beat_s    = in_valid && in_ready;
    // cnt_q < MAX_BEATS whenever this is used, so the increment never wraps.
    assign cnt_inc_s = cnt_q + CW'(1);

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (beat_s) begin
                    acc_d   = in_data;
                    op_d    = op;
                    cnt_d   = CW'(1);
                    state_d = in_last ? S_DONE : S_ACC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACC: begin
                if (beat_s) begin
                    acc_d = fold_word(op_q, acc_q, in_data);
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == CW'(MAX_BEATS)) begin
                        state_d = S_DONE;
                        err_d   = ~in_last;
                    end else if (in_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACC;
                    end
                end else begin
                    state_d = S_ACC;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            op_q    <= 2'b00;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Outputs depend only on registers that are frozen while in DONE.
    assign out_data = (op_q == 2'b11) ? ~acc_q : acc_q;
    assign out_red  = reduce_word(op_q, acc_q);
    assign out_err  = err_q;
`ifdef REDUCE_BEATCNT_EN
    assign out_beats = cnt_q;
`endif

endmodule

// File: tb/tb_reduce_stream_acc.sv
// Self-checking bench for reduce_stream_acc: a frame-level reference model
// (queue of accepted beats folded at frame end) checked every cycle, plus
// directed vectors with literal expected values.
module tb_reduce_stream_acc;

    localparam int W         = 8;
    localparam int MAX_BEATS = 16;
    localparam int CW        = $clog2(MAX_BEATS + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_red;
    logic          out_err;
    logic          out_valid;
    logic          out_ready = 1'b0;
`ifdef REDUCE_BEATCNT_EN
    logic [CW-1:0] out_beats;
`endif

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    reduce_stream_acc #(.W(W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_red   (out_red),
        .out_err   (out_err),
        .out_valid (out_valid),
`ifdef REDUCE_BEATCNT_EN
        .out_beats (out_beats),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] frame[$];
    logic [1:0]   fop = 2'b00;
    bit           pend = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic         exp_red = 1'b0;
    logic         exp_err = 1'b0;
    int           exp_beats = 0;

    function automatic logic [W-1:0] fold_frame(input logic [W-1:0] q[$],
                                                input logic [1:0] o);
        logic [W-1:0] a;
        a = q[0];
        for (int i = 1; i < q.size(); i++) begin
            if (o == 2'b01)      a = a | q[i];
            else if (o == 2'b10) a = a ^ q[i];
            else                 a = a & q[i];
        end
        return a;
    endfunction

    function automatic logic red_of(input logic [W-1:0] a, input logic [1:0] o);
        if (o == 2'b00)      return &a;
        else if (o == 2'b01) return |a;
        else if (o == 2'b10) return ^a;
        else                 return ~&a;
    endfunction

    always @(posedge clk) begin
        logic [W-1:0] a;
        logic [1:0]   o;
        if (reset) begin
            pend <= 1'b0;
            frame.delete();
        end else if (pend) begin
            if (out_ready) pend <= 1'b0;
        end else if (in_valid) begin
            o = (frame.size() == 0) ? op : fop;
            fop <= o;
            frame.push_back(in_data);
            if (in_last || frame.size() == MAX_BEATS) begin
                a = fold_frame(frame, o);
                exp_data  <= (o == 2'b11) ? ~a : a;
                exp_red   <= red_of(a, o);
                exp_err   <= !in_last;
                exp_beats <= frame.size();
                pend      <= 1'b1;
                frame.delete();
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_in_ready", in_ready, !pend);
            check("m_out_valid", out_valid, pend);
            if (pend) begin
                check("m_out_data", out_data, exp_data);
                check("m_out_red", out_red, exp_red);
                check("m_out_err", out_err, exp_err);
`ifdef REDUCE_BEATCNT_EN
                check("m_out_beats", out_beats, exp_beats);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic beat(input logic [1:0] o, input logic [W-1:0] d,
                        input logic l, output int stalls);
        stalls = 0;
        op = o; in_data = d; in_last = l; in_valid = 1'b1;
        while (!in_ready && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 50) check("beat_timeout", 64'd1, 64'd0);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int s;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_red", out_red, 1'b0);
        check("rst_err", out_err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
`ifdef REDUCE_BEATCNT_EN
        check("rst_beats", out_beats, 0);
`endif

        // AND frame
        beat(2'b00, 8'hFF, 1'b0, s);
        beat(2'b00, 8'hF0, 1'b0, s);
        beat(2'b00, 8'h3C, 1'b1, s);
        check("and_valid", out_valid, 1'b1);
        check("and_data", out_data, 8'h30);
        check("and_red", out_red, 1'b0);
        check("and_err", out_err, 1'b0);

        // OR then XOR back-to-back with out_ready held high
        out_ready = 1'b1;
        @(negedge clk);
        beat(2'b01, 8'h01, 1'b0, s);
        beat(2'b01, 8'h80, 1'b1, s);
        check("or_data", out_data, 8'h81);
        check("or_red", out_red, 1'b1);
        check("or_in_ready", in_ready, 1'b0);
        beat(2'b10, 8'h0F, 1'b0, s);
        check("gap_cycles", s, 1);
        beat(2'b10, 8'hFF, 1'b1, s);
        check("xor_data", out_data, 8'hF0);
        check("xor_red", out_red, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;

        // NAND single beat, op change during DONE, then backpressure
        beat(2'b11, 8'hAA, 1'b1, s);
        check("nand_data", out_data, 8'h55);
        check("nand_red", out_red, 1'b1);
        op = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1'b1);
            check("bp_data", out_data, 8'h55);
            check("bp_red", out_red, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
        end
        release_result();
        check("rel_in_ready", in_ready, 1'b1);
        check("rel_valid", out_valid, 1'b0);

        // Overflow: 17 beats of 0xFF, last only on the 17th
        for (int i = 0; i < 16; i++) beat(2'b00, 8'hFF, 1'b0, s);
        check("ovf_valid", out_valid, 1'b1);
        check("ovf_data", out_data, 8'hFF);
        check("ovf_err", out_err, 1'b1);
`ifdef REDUCE_BEATCNT_EN
        check("ovf_beats", out_beats, 16);
`endif
        release_result();
        beat(2'b00, 8'hFF, 1'b1, s);
        check("tail_data", out_data, 8'hFF);
        check("tail_err", out_err, 1'b0);
`ifdef REDUCE_BEATCNT_EN
        check("tail_beats", out_beats, 1);
`endif
        release_result();

        // Reset mid-frame, then a clean frame
        beat(2'b10, 8'h33, 1'b0, s);
        beat(2'b10, 8'h77, 1'b0, s);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_valid", out_valid, 1'b0);
        check("mrst_data", out_data, 8'h00);
        check("mrst_red", out_red, 1'b0);
        check("mrst_err", out_err, 1'b0);
        check("mrst_in_ready", in_ready, 1'b1);
        beat(2'b00, 8'h0F, 1'b0, s);
        beat(2'b00, 8'h0F, 1'b1, s);
        check("post_data", out_data, 8'h0F);
        check("post_err", out_err, 1'b0);
        release_result();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
